div_sqrt_sched_mvp: RTL and testbench

Round-robin scheduler and iteration sequencer for the shared iterative div/sqrt datapath. Arbitrates div/sqrt requests from NUM_REQ requesters (e.g. FPU lanes) and latches the winner's operation and format. Computes the iteration count from format, precision control and iteration-unit number, then steps the datapath through load, iterate and finish phases and returns a done pulse to the owning requester.

---
 rtl/div_sqrt_sched_mvp.sv | 188 ++++++++++++++++++
 tb/tb_div_sqrt_sched_mvp.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sqrt_sched_mvp.sv
// div_sqrt_sched_mvp
// Round-robin scheduler and iteration sequencer for a shared iterative
// div/sqrt datapath. Picks one of NUM_REQ requesters, latches its operation,
// then walks the datapath through LOAD -> ITER -> FIN and pulses Done back
// to the requester that owns the operation.
//
// Ports:
//   Clk_CI, Rst_RI          clock, async active-high reset
//   Valid_SI / Ready_SO     per-requester handshake (Ready only in IDLE)
//   Op_SI, Format_SI,
//   Special_SI              per-requester operation description
//   Precision_Ctl_SI        0 = full precision, else mantissa bits incl. hidden
//   Iteration_Unit_Num_SI   quotient bits per cycle minus one
//   Kill_SI                 abort current operation
//   Div_start_SO,
//   Sqrt_start_SO           one-cycle start pulse in LOAD
//   Format_SO, Owner_DO     latched format / owner of current operation
//   Iter_Cnt_DO,
//   Iter_Last_SO            remaining iterations, final-iteration flag
//   Busy_SO, Done_SO        activity flag, one-cycle completion per owner
module div_sqrt_sched_mvp #(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 6
) (
  input  logic                 Clk_CI,
  input  logic                 Rst_RI,
  input  logic [NUM_REQ-1:0]   Valid_SI,
  output logic [NUM_REQ-1:0]   Ready_SO,
  input  logic [NUM_REQ-1:0]   Op_SI,
  input  logic [2*NUM_REQ-1:0] Format_SI,
  input  logic [NUM_REQ-1:0]   Special_SI,
  input  logic [5:0]           Precision_Ctl_SI,
  input  logic [1:0]           Iteration_Unit_Num_SI,
  input  logic                 Kill_SI,
  output logic                 Div_start_SO,
  output logic                 Sqrt_start_SO,
  output logic [1:0]           Format_SO,
  output logic [CNT_W-1:0]     Iter_Cnt_DO,
  output logic                 Iter_Last_SO,
  output logic [1:0]           Owner_DO,
  output logic                 Busy_SO,
  output logic [NUM_REQ-1:0]   Done_SO
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_FIN} state_t;

  state_t           r_state, w_stateNext;
  logic [1:0]       r_ptr;
  logic             r_op;
  logic             r_special;
  logic [1:0]       r_fmt;
  logic [1:0]       r_owner;
  logic [CNT_W-1:0] r_cntInit;
  logic [CNT_W-1:0] r_cnt;

  logic             w_found;
  logic [1:0]       w_winner;
  logic             w_winOp;
  logic [1:0]       w_winFmt;
  logic             w_winSpec;
  logic             w_accept;
  logic [1:0]       w_ptrNext;
  logic [5:0]       w_full;
  logic [5:0]       w_prec;
  logic [6:0]       w_bits;
  logic [6:0]       w_n;
  logic [CNT_W-1:0] w_nm1;

  // Round-robin search: scan offsets from the pointer outward and take the
  // first asserted Valid. The inner loop keeps every index a constant.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_winOp   = 1'b0;
    w_winFmt  = '0;
    w_winSpec = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && Valid_SI[i] && ((int'(r_ptr) + k) % NUM_REQ == i)) begin
          w_found   = 1'b1;
          w_winner  = 2'(i);
          w_winOp   = Op_SI[i];
          w_winFmt  = Format_SI[2*i +: 2];
          w_winSpec = Special_SI[i];
        end
      end
    end
  end

  assign w_accept  = (r_state == S_IDLE) && !Kill_SI && w_found;
  assign w_ptrNext = (int'(w_winner) == NUM_REQ - 1) ? 2'd0 : w_winner + 2'd1;

  always_comb begin
    Ready_SO = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      Ready_SO[i] = w_accept && (w_winner == 2'(i));
    end
  end

  // Iteration count for the winner: precision clamped to the format's full
  // mantissa, two extra bits for guard and round, divided (rounding up) by
  // the number of quotient bits produced per cycle.
  always_comb begin
    w_full = 6'd24;
    case (w_winFmt)
      2'b00: w_full = 6'd24;
      2'b01: w_full = 6'd53;
      2'b10: w_full = 6'd11;
      2'b11: w_full = 6'd8;
      default: w_full = 6'd24;
    endcase
    w_prec = ((Precision_Ctl_SI == 6'd0) || (Precision_Ctl_SI > w_full)) ?
             w_full : Precision_Ctl_SI;
    w_bits = {1'b0, w_prec} + 7'd2;
    w_n    = w_bits;
    case (Iteration_Unit_Num_SI)
      2'd0: w_n = w_bits;
      2'd1: w_n = (w_bits + 7'd1) >> 1;
      2'd2: w_n = (w_bits + 7'd2) / 7'd3;
      2'd3: w_n = (w_bits + 7'd3) >> 2;
      default: w_n = w_bits;
    endcase
    w_nm1 = CNT_W'(w_n - 7'd1);
  end

  // State register plus everything latched at accept. The counter is loaded
  // in LOAD and only decrements while nonzero, so it never wraps.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_op      <= 1'b0;
      r_special <= 1'b0;
      r_fmt     <= '0;
      r_owner   <= '0;
      r_cntInit <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_accept) begin
        r_op      <= w_winOp;
        r_special <= w_winSpec;
        r_fmt     <= w_winFmt;
        r_owner   <= w_winner;
        r_cntInit <= w_nm1;
        r_ptr     <= w_ptrNext;
      end
      if (Kill_SI && (r_state != S_IDLE)) begin
        r_cnt <= '0;
      end else if (r_state == S_LOAD) begin
        r_cnt <= r_cntInit;
      end else if ((r_state == S_ITER) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Next-state logic; a kill outside IDLE overrides every other transition.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_stateNext = S_LOAD;
      S_LOAD: w_stateNext = r_special ? S_FIN : S_ITER;
      S_ITER: if (r_cnt == '0) w_stateNext = S_FIN;
      S_FIN:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
    if (Kill_SI && (r_state != S_IDLE)) begin
      w_stateNext = S_IDLE;
    end
  end

  always_comb begin
    Done_SO = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      Done_SO[i] = (r_state == S_FIN) && !Kill_SI && (r_owner == 2'(i));
    end
  end

  assign Div_start_SO  = (r_state == S_LOAD) && !r_op;
  assign Sqrt_start_SO = (r_state == S_LOAD) && r_op;
  assign Format_SO     = r_fmt;
  assign Owner_DO      = r_owner;
  assign Iter_Cnt_DO   = r_cnt;
  assign Iter_Last_SO  = (r_state == S_ITER) && (r_cnt == '0);
  assign Busy_SO       = (r_state != S_IDLE);

endmodule

// File: tb/tb_div_sqrt_sched_mvp.sv
// tb_div_sqrt_sched_mvp
// Directed bench for the div/sqrt scheduler. Each accepted request pushes
// its expected owner and iteration count into a queue; the Done pulse pops
// it and checks owner and accept-to-done latency.
module tb_div_sqrt_sched_mvp;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 6;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   valid;
  logic [NUM_REQ-1:0]   ready;
  logic [NUM_REQ-1:0]   op;
  logic [2*NUM_REQ-1:0] fmt;
  logic [NUM_REQ-1:0]   special;
  logic [5:0]           pc;
  logic [1:0]           iun;
  logic                 kill;
  logic                 divStart;
  logic                 sqrtStart;
  logic [1:0]           fmtOut;
  logic [CNT_W-1:0]     iterCnt;
  logic                 iterLast;
  logic [1:0]           owner;
  logic                 busy;
  logic [NUM_REQ-1:0]   done;

  typedef struct {
    int owner;
    int n;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  int   expPtr = 0;

  div_sqrt_sched_mvp #(.NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .Clk_CI                (clk),
    .Rst_RI                (rst),
    .Valid_SI              (valid),
    .Ready_SO              (ready),
    .Op_SI                 (op),
    .Format_SI             (fmt),
    .Special_SI            (special),
    .Precision_Ctl_SI      (pc),
    .Iteration_Unit_Num_SI (iun),
    .Kill_SI               (kill),
    .Div_start_SO          (divStart),
    .Sqrt_start_SO         (sqrtStart),
    .Format_SO             (fmtOut),
    .Iter_Cnt_DO           (iterCnt),
    .Iter_Last_SO          (iterLast),
    .Owner_DO              (owner),
    .Busy_SO               (busy),
    .Done_SO               (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Smallest n with n*U >= precision+2, precision clamped to the format.
  function automatic int modelN(input logic [1:0] f, input int p, input int u);
    int full;
    int prec;
    int n;
    case (f)
      2'b00: full = 24;
      2'b01: full = 53;
      2'b10: full = 11;
      default: full = 8;
    endcase
    prec = (p == 0 || p > full) ? full : p;
    n = 0;
    while (n * (u + 1) < prec + 2) n++;
    return n;
  endfunction

  function automatic int modelWinner(input logic [NUM_REQ-1:0] vm, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (vm[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive one request pattern, follow it through to Done and check each
  // phase. Ends in the IDLE cycle right after FIN. With keep=1 the valid
  // mask stays asserted so the next call starts in that same cycle.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] vm, input bit keep,
                               input logic o, input logic [1:0] f, input logic s,
                               input logic [5:0] p, input logic [1:0] u);
    int   win;
    int   n;
    int   cycles;
    exp_t e;
    win = modelWinner(vm, expPtr);
    n = s ? 0 : modelN(f, int'(p), int'(u));
    valid = vm;
    op = {NUM_REQ{o}};
    fmt = {NUM_REQ{f}};
    special = {NUM_REQ{s}};
    pc = p;
    iun = u;
    #1;
    checkOutput("ready_grant", 32'(ready), 32'(1 << win));
    expQ.push_back('{owner: win, n: n});
    expPtr = (win + 1) % NUM_REQ;
    stepCycle();
    cycles = 1;
    if (!keep) valid = '0;
    pc = ~p;
    iun = ~u;
    checkOutput("load_busy", 32'(busy), 32'd1);
    checkOutput("load_div", 32'(divStart), 32'(!o));
    checkOutput("load_sqrt", 32'(sqrtStart), 32'(o));
    checkOutput("load_fmt", 32'(fmtOut), 32'(f));
    checkOutput("load_owner", 32'(owner), 32'(win));
    checkOutput("load_ready", 32'(ready), 32'd0);
    checkOutput("load_last", 32'(iterLast), 32'd0);
    for (int k = n - 1; k >= 0; k--) begin
      stepCycle();
      cycles++;
      checkOutput("iter_cnt", 32'(iterCnt), 32'(k));
      checkOutput("iter_last", 32'(iterLast), 32'(k == 0));
      checkOutput("iter_done", 32'(done), 32'd0);
    end
    stepCycle();
    cycles++;
    checkOutput("fin_last", 32'(iterLast), 32'd0);
    if (expQ.size() == 0) begin
      checkOutput("queue_empty_at_done", 32'd0, 32'd1);
    end else begin
      e = expQ.pop_front();
      checkOutput("fin_done", 32'(done), 32'(1 << e.owner));
      checkOutput("fin_owner", 32'(owner), 32'(e.owner));
      checkOutput("latency", 32'(cycles), 32'(e.n + 2));
    end
    stepCycle();
    checkOutput("post_busy", 32'(busy), 32'd0);
    checkOutput("post_done", 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    op = '0;
    fmt = '0;
    special = '0;
    pc = '0;
    iun = '0;
    kill = 1'b0;
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(ready), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_cnt", 32'(iterCnt), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    #10;
    rst = 1'b0;
    stepCycle();

    $display("[TB] kill in IDLE suppresses ready");
    valid = 2'b01;
    kill = 1'b1;
    #1;
    checkOutput("kill_idle_ready", 32'(ready), 32'd0);
    stepCycle();
    checkOutput("kill_idle_busy", 32'(busy), 32'd0);
    kill = 1'b0;
    valid = '0;

    $display("[TB] directed iteration counts");
    applyStimulus(2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 6'd0,  2'd2);
    applyStimulus(2'b10, 1'b0, 1'b1, 2'b01, 1'b0, 6'd0,  2'd3);
    applyStimulus(2'b01, 1'b0, 1'b0, 2'b11, 1'b0, 6'd0,  2'd1);
    applyStimulus(2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 6'd12, 2'd1);
    applyStimulus(2'b01, 1'b0, 1'b0, 2'b10, 1'b0, 6'd40, 2'd0);

    $display("[TB] special operands bypass iteration");
    applyStimulus(2'b10, 1'b0, 1'b0, 2'b01, 1'b1, 6'd0, 2'd0);

    $display("[TB] round-robin with both requesters valid");
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 6'd0, 2'd3);
    applyStimulus(2'b11, 1'b1, 1'b1, 2'b11, 1'b0, 6'd0, 2'd3);
    applyStimulus(2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 6'd0, 2'd3);
    applyStimulus(2'b11, 1'b0, 1'b1, 2'b11, 1'b0, 6'd0, 2'd3);

    $display("[TB] kill mid-iteration");
    valid = 2'b01;
    op = '0;
    fmt = {NUM_REQ{2'b00}};
    special = '0;
    pc = 6'd0;
    iun = 2'd2;
    #1;
    checkOutput("kill_grant", 32'(ready), 32'(1 << modelWinner(2'b01, expPtr)));
    expPtr = 1;
    stepCycle();
    valid = '0;
    for (int k = 0; k < 5; k++) stepCycle();
    checkOutput("kill_cnt_before", 32'(iterCnt), 32'd4);
    kill = 1'b1;
    stepCycle();
    kill = 1'b0;
    checkOutput("kill_busy", 32'(busy), 32'd0);
    checkOutput("kill_cnt", 32'(iterCnt), 32'd0);
    checkOutput("kill_done", 32'(done), 32'd0);
    stepCycle();
    checkOutput("kill_done_after", 32'(done), 32'd0);
    applyStimulus(2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 6'd0, 2'd2);

    $display("[TB] reset mid-iteration");
    valid = 2'b01;
    fmt = {NUM_REQ{2'b10}};
    pc = 6'd0;
    iun = 2'd0;
    stepCycle();
    valid = '0;
    stepCycle();
    stepCycle();
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_cnt", 32'(iterCnt), 32'd0);
    checkOutput("mid_rst_fmt", 32'(fmtOut), 32'd0);
    checkOutput("mid_rst_owner", 32'(owner), 32'd0);
    checkOutput("mid_rst_done", 32'(done), 32'd0);
    checkOutput("mid_rst_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    expPtr = 0;
    stepCycle();
    applyStimulus(2'b11, 1'b0, 1'b1, 2'b01, 1'b0, 6'd0, 2'd3);

    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
